bram_dma: RTL and testbench
===========================

# bram_dma

Bus-initiator block-move engine for the 512x32 byte-addressable block RAM. Given a start pulse, it copies a run of words from one RAM region to another, or fills a region with a constant word. It drives the same sel/we/addr/wdat/rdat port the CPU uses, through a request/grant handshake with the system bus mux. It sits beside the RISC-V core as a memory-mapped peripheral, so firmware can offload clears and buffer moves.

## Interface
- No parameters. Widths are fixed by the 512x32 RAM: 9-bit word index, 11-bit byte address.
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse; latches the command when idle
- fill  in  1  1 = fill mode, 0 = copy mode
- src  in  9  copy source word index
- dst  in  9  destination word index
- len  in  10  word count, 0..512
- fill_val  in  32  fill data
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at completion
- mem_req  out  1  bus request to the arbiter
- mem_gnt  in  1  bus grant; the engine drives the RAM only while granted
- mem_sel  out  1  RAM select
- mem_we  out  4  byte write enables
- mem_addr  out  11  RAM byte address; bits [1:0] are always 0
- mem_wdat  out  32  write data
- mem_rdat  in  32  RAM read data, valid one clk after the read address

## Operation
- States: IDLE, RD, WR, FILL, DONE.
- IDLE
  - start=1 latches src, dst, len, fill, fill_val and sets busy.
  - len==0: go to DONE.
  - Otherwise go to FILL if fill=1, else RD.
- RD
  - Drives mem_sel=1, mem_we=0, mem_addr={src_ptr,2'b00}.
  - Advances to WR only on a cycle with mem_gnt=1.
- WR
  - Drives mem_sel=1, mem_we=4'hF, mem_addr={dst_ptr,2'b00}, mem_wdat=captured rdat.
  - On mem_gnt=1: increments both pointers, decrements count, then goes to DONE if count becomes 0, else RD.
- FILL
  - Drives mem_we=4'hF and mem_wdat=fill_val at dst_ptr.
  - Each granted cycle writes one word. Leaves for DONE when count reaches 0.
- DONE
  - Pulses done for one cycle, clears busy, returns to IDLE.
- Pointers are 9-bit and wrap from 511 to 0. len=512 covers the whole RAM.
- Overlapping regions are copied strictly in ascending order. Overlap with dst>src is not corrected; the result is defined by that ordering.
- mem_req is high in RD, WR and FILL.
- When mem_gnt=0: mem_sel=0, mem_we=0, and the state, pointers and count hold.
- start while busy is ignored.

## Timing
- Reset values: busy=0, done=0, mem_req=0, mem_sel=0, mem_we=0, mem_addr=0, mem_wdat=0, state=IDLE.
- rst_n=0 mid-transfer aborts immediately. No done pulse; the RAM keeps any partial writes.
- All outputs are registered.
- Read capture: rdat is sampled into the write register on the first clk edge after the granted RD cycle, i.e. on entry to WR.
- With continuous grant:
  - copy takes 2 clk per word;
  - fill takes 1 clk per word;
  - start to first mem_sel is 1 clk;
  - the last write is followed by done 1 clk later;
  - busy falls in the same cycle done is high.
- len==0: done 2 clk after start, no bus activity.
- A grant dropped between RD and WR keeps the captured word valid, because the capture register loads only once.

## Configuration
- BRAM_DMA_FILL_EN
  - Defined: FILL state and fill_val register are present.
  - Undefined: the fill input is ignored, the engine always copies, and the fill_val port remains but is unused.

## Structure
- Shared package bram_dma_pkg holds:
  - state enum and encoding;
  - constants for word-index width (9), byte-address width (11), count width (10);
  - WE_ALL = 4'hF.
- One sub-module, bram_dma_ctr: loadable 9-bit wrapping pointer with increment enable, instantiated twice (src_ptr, dst_ptr).

## Test plan
- Copy, full grant: RAM preloaded with word i = 0xA5000000+i. src=0, dst=100, len=4 → words 100..103 = 0xA5000000..0xA5000003; done 9 clk after start; no other address written.
- Fill: dst=510, len=4, fill_val=0xDEADBEEF → words 510, 511, 0, 1 written (wrap); done 5 clk after start.
- Grant stall: copy len=2 with mem_gnt toggled 1,0,0,1,...
  - mem_sel is never high while mem_gnt=0;
  - the copied data is still correct;
  - done asserts after exactly 4 granted cycles.
- len=0 and start-while-busy:
  - len=0 gives done at +2 clk with mem_sel never asserted;
  - a second start during a len=8 copy leaves the src/dst/len results unchanged.
- Reset mid-copy: rst_n=0 in the 3rd WR cycle of a len=8 copy → next clk busy=0, mem_sel=0, done never pulses, words beyond the 3rd are untouched.
- Macro off (BRAM_DMA_FILL_EN undefined): fill=1, src=0, dst=8, len=2 → performs a copy of words 0..1 to 8..9.

Source files
------------

// File: rtl/bram_dma_pkg.sv
// bram_dma_pkg: shared types and constants for the bram_dma block-move engine.
//   - state_e     : engine FSM states
//   - WordIdxW    : RAM word-index width (512 words)
//   - ByteAddrW   : RAM byte-address width
//   - CntW        : transfer word-count width (0..512)
//   - WE_ALL      : full-word byte-enable mask
//   - word_to_byte: word index -> word-aligned byte address
package bram_dma_pkg;

  localparam int unsigned WordIdxW  = 9;
  localparam int unsigned ByteAddrW = 11;
  localparam int unsigned CntW      = 10;

  localparam logic [3:0] WE_ALL = 4'hF;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StRd   = 3'd1,
    StWr   = 3'd2,
    StFill = 3'd3,
    StDone = 3'd4
  } state_e;

  function automatic logic [ByteAddrW-1:0] word_to_byte(input logic [WordIdxW-1:0] idx);
    return {idx, 2'b00};
  endfunction

endpackage

// File: rtl/bram_dma_if.sv
// bram_dma_if: request/grant RAM bus shared by the DMA engine and the system bus mux.
//   mem_req  : initiator wants the bus
//   mem_gnt  : bus granted to the initiator this cycle
//   mem_sel  : RAM select
//   mem_we   : byte write enables
//   mem_addr : byte address, word aligned
//   mem_wdat : write data
//   mem_rdat : read data, valid one clock after the read address
// Modports: master (DMA engine), slave (arbiter/RAM side).
interface bram_dma_if;
  import bram_dma_pkg::*;

  logic                 mem_req;
  logic                 mem_gnt;
  logic                 mem_sel;
  logic [3:0]           mem_we;
  logic [ByteAddrW-1:0] mem_addr;
  logic [31:0]          mem_wdat;
  logic [31:0]          mem_rdat;

  modport master (
    output mem_req,
    output mem_sel,
    output mem_we,
    output mem_addr,
    output mem_wdat,
    input  mem_gnt,
    input  mem_rdat
  );

  modport slave (
    input  mem_req,
    input  mem_sel,
    input  mem_we,
    input  mem_addr,
    input  mem_wdat,
    output mem_gnt,
    output mem_rdat
  );

endinterface

// File: rtl/bram_dma_ctr.sv
// bram_dma_ctr: loadable 9-bit word pointer that wraps from 511 to 0.
//   i_clk      : clock
//   i_rst_n    : synchronous active-low reset
//   i_load     : load i_load_val (has priority over i_inc)
//   i_load_val : value to load
//   i_inc      : advance pointer by one
//   o_ptr_nxt  : pointer value that will be held after the coming edge
module bram_dma_ctr
  import bram_dma_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_load,
  input  logic [WordIdxW-1:0] i_load_val,
  input  logic                i_inc,
  output logic [WordIdxW-1:0] o_ptr_nxt
);

  logic [WordIdxW-1:0] r_ptr;
  logic [WordIdxW-1:0] w_ptr_nxt;

  always_comb begin
    w_ptr_nxt = r_ptr;
    if (i_load) begin
      w_ptr_nxt = i_load_val;
    end else if (i_inc) begin
      // Natural 9-bit overflow gives the 511 -> 0 wrap.
      w_ptr_nxt = r_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
    end else begin
      r_ptr <= w_ptr_nxt;
    end
  end

  // The owner registers its bus address from this, so it must be the post-edge value.
  assign o_ptr_nxt = w_ptr_nxt;

endmodule

// File: rtl/bram_dma.sv
// bram_dma: block-move engine for the 512x32 block RAM. Copies len words from src to dst
// (ascending, wrapping) or fills len words at dst with fill_val.
//   i_clk      : system clock
//   i_rst_n    : synchronous active-low reset
//   i_start    : one-cycle command pulse, accepted only when idle
//   i_fill     : 1 = fill, 0 = copy
//   i_src      : copy source word index
//   i_dst      : destination word index
//   i_len      : word count 0..512
//   i_fill_val : fill data
//   o_busy     : command in progress
//   o_done     : one-cycle completion pulse
//   io_mem     : RAM bus (bram_dma_if.master)
// Build option: define BRAM_DMA_FILL_EN to include fill mode; otherwise every command copies.
module bram_dma
  import bram_dma_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic                i_fill,
  input  logic [WordIdxW-1:0] i_src,
  input  logic [WordIdxW-1:0] i_dst,
  input  logic [CntW-1:0]     i_len,
  input  logic [31:0]         i_fill_val,
  output logic                o_busy,
  output logic                o_done,
  bram_dma_if.master          io_mem
);

  state_e                r_state;
  state_e                w_state_nxt;
  logic                  r_zlen;
  logic                  w_zlen_nxt;
  logic [CntW-1:0]       r_cnt;
  logic [CntW-1:0]       w_cnt_nxt;

  logic                  w_load;
  logic                  w_src_inc;
  logic                  w_dst_inc;
  logic                  w_cap;
  logic                  w_fill_req;
  logic                  w_gnt;

  logic [WordIdxW-1:0]   w_src_nxt;
  logic [WordIdxW-1:0]   w_dst_nxt;

  logic                  r_req;
  logic                  r_sel;
  logic [3:0]            r_we;
  logic [ByteAddrW-1:0]  r_addr;
  logic [31:0]           r_wdat;
  logic                  r_busy;
  logic                  r_done;

  logic                  w_active_nxt;
  logic                  w_write_nxt;
  logic                  w_done_nxt;
  logic                  w_busy_nxt;
  logic [ByteAddrW-1:0]  w_addr_nxt;
  logic [31:0]           w_wdat_nxt;

  assign w_gnt = io_mem.mem_gnt;

`ifdef BRAM_DMA_FILL_EN
  assign w_fill_req = i_fill;
`else
  assign w_fill_req = 1'b0;
  logic w_unused;
  assign w_unused = ^{i_fill, i_fill_val};
`endif

  bram_dma_ctr u_src_ctr (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_load),
    .i_load_val (i_src),
    .i_inc      (w_src_inc),
    .o_ptr_nxt  (w_src_nxt)
  );

  bram_dma_ctr u_dst_ctr (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_load),
    .i_load_val (i_dst),
    .i_inc      (w_dst_inc),
    .o_ptr_nxt  (w_dst_nxt)
  );

  // Next-state logic. Without grant every branch holds state, pointers and count.
  always_comb begin
    w_state_nxt = r_state;
    w_zlen_nxt  = r_zlen;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    w_src_inc   = 1'b0;
    w_dst_inc   = 1'b0;
    w_cap       = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_load    = 1'b1;
          w_cnt_nxt = i_len;
          if (i_len == '0) begin
            w_state_nxt = StDone;
            w_zlen_nxt  = 1'b1;
          end else if (w_fill_req) begin
            w_state_nxt = StFill;
          end else begin
            w_state_nxt = StRd;
          end
        end
      end
      StRd: begin
        if (w_gnt) begin
          w_state_nxt = StWr;
          w_cap       = 1'b1;
        end
      end
      StWr: begin
        if (w_gnt) begin
          w_src_inc   = 1'b1;
          w_dst_inc   = 1'b1;
          w_cnt_nxt   = r_cnt - 1'b1;
          w_state_nxt = (r_cnt == CntW'(1)) ? StDone : StRd;
        end
      end
      StFill: begin
        if (w_gnt) begin
          w_dst_inc   = 1'b1;
          w_cnt_nxt   = r_cnt - 1'b1;
          w_state_nxt = (r_cnt == CntW'(1)) ? StDone : StFill;
        end
      end
      StDone: begin
        // A zero-length command idles one extra cycle here so done lands two clocks
        // after start, without ever touching the bus.
        if (r_zlen) begin
          w_zlen_nxt = 1'b0;
        end else begin
          w_state_nxt = StIdle;
        end
      end
      default: begin
        w_state_nxt = StIdle;
        w_zlen_nxt  = 1'b0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_comb begin
    w_active_nxt = (w_state_nxt == StRd) || (w_state_nxt == StWr) || (w_state_nxt == StFill);
    w_write_nxt  = (w_state_nxt == StWr) || (w_state_nxt == StFill);
    w_done_nxt   = (w_state_nxt == StDone) && !w_zlen_nxt;
    w_busy_nxt   = (w_state_nxt != StIdle) && !w_done_nxt;

    w_addr_nxt = '0;
    if (w_state_nxt == StRd) begin
      w_addr_nxt = word_to_byte(w_src_nxt);
    end else if (w_write_nxt) begin
      w_addr_nxt = word_to_byte(w_dst_nxt);
    end

    // The write register loads read data exactly once per word, so a grant gap in WR
    // cannot corrupt it. In fill mode it doubles as the latched fill value.
    w_wdat_nxt = r_wdat;
    if (w_cap) begin
      w_wdat_nxt = io_mem.mem_rdat;
    end
`ifdef BRAM_DMA_FILL_EN
    else if (w_load && i_fill) begin
      w_wdat_nxt = i_fill_val;
    end
`endif
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_zlen  <= 1'b0;
      r_cnt   <= '0;
      r_req   <= 1'b0;
      r_sel   <= 1'b0;
      r_we    <= '0;
      r_addr  <= '0;
      r_wdat  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_zlen  <= w_zlen_nxt;
      r_cnt   <= w_cnt_nxt;
      r_req   <= w_active_nxt;
      r_sel   <= w_active_nxt;
      r_we    <= w_write_nxt ? WE_ALL : 4'h0;
      r_addr  <= w_addr_nxt;
      r_wdat  <= w_wdat_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Select and write strobes are qualified by grant so the RAM is never driven without
  // bus ownership; the held request keeps asking.
  assign io_mem.mem_req  = r_req;
  assign io_mem.mem_sel  = r_sel & w_gnt;
  assign io_mem.mem_we   = r_we & {4{w_gnt}};
  assign io_mem.mem_addr = r_addr;
  assign io_mem.mem_wdat = r_wdat;

  assign o_busy = r_busy;
  assign o_done = r_done;

endmodule

// File: tb/tb_bram_dma.sv
// tb_bram_dma: directed bench for bram_dma with a behavioural 512x32 RAM, a write/done
// scoreboard filled by the stimulus and drained by an independent monitor.
module tb_bram_dma;

  typedef struct packed {
    logic [10:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        fill = 1'b0;
  logic [8:0]  src = '0;
  logic [8:0]  dst = '0;
  logic [9:0]  len = '0;
  logic [31:0] fill_val = '0;
  logic        gnt = 1'b1;
  logic        busy;
  logic        done;

  logic [31:0] ram [512];
  int          cyc = 0;
  int          n_total = 0;
  int          n_bad = 0;
  bit          sel_seen = 1'b0;

  wr_t exp_wr[$];
  int  exp_done[$];

  bram_dma_if u_bus ();

  bram_dma u_dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .i_fill     (fill),
    .i_src      (src),
    .i_dst      (dst),
    .i_len      (len),
    .i_fill_val (fill_val),
    .o_busy     (busy),
    .o_done     (done),
    .io_mem     (u_bus)
  );

  always #5 clk = ~clk;

  assign u_bus.mem_gnt  = gnt;
  assign u_bus.mem_rdat = ram[u_bus.mem_addr[10:2]];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (u_bus.mem_sel && (u_bus.mem_we != 4'h0)) begin
      ram[u_bus.mem_addr[10:2]] <= u_bus.mem_wdat;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Monitor: checks every RAM write and done pulse against the scoreboard.
  always @(negedge clk) begin
    if (u_bus.mem_sel) sel_seen = 1'b1;
    if (!gnt) chk("sel_without_grant", {63'd0, u_bus.mem_sel}, 64'd0);
    if (u_bus.mem_sel && (u_bus.mem_we != 4'h0)) begin
      if (exp_wr.size() == 0) begin
        n_total++;
        n_bad++;
        $display("FAIL wr_unexpected: got addr=%0h data=%0h want no write",
                 u_bus.mem_addr, u_bus.mem_wdat);
      end else begin
        wr_t e;
        e = exp_wr.pop_front();
        chk("wr_addr", {53'd0, u_bus.mem_addr}, {53'd0, e.addr});
        chk("wr_data", {32'd0, u_bus.mem_wdat}, {32'd0, e.data});
        chk("wr_we", {60'd0, u_bus.mem_we}, 64'hF);
      end
    end
    if (done) begin
      chk("busy_low_at_done", {63'd0, busy}, 64'd0);
      if (exp_done.size() == 0) begin
        n_total++;
        n_bad++;
        $display("FAIL done_unexpected: got done at cycle %0d want none", cyc);
      end else begin
        chk("done_cycle", 64'(cyc), 64'(exp_done.pop_front()));
      end
    end
  end

  task automatic exp_copy(input logic [8:0] s, input logic [8:0] d, input int l);
    for (int k = 0; k < l; k++) begin
      wr_t e;
      logic [8:0] si;
      logic [8:0] di;
      si = s + 9'(k);
      di = d + 9'(k);
      e.addr = {di, 2'b00};
      e.data = 32'hA500_0000 + {23'd0, si};
      exp_wr.push_back(e);
    end
  endtask

  task automatic exp_word(input logic [8:0] d, input logic [31:0] v);
    wr_t e;
    e.addr = {d, 2'b00};
    e.data = v;
    exp_wr.push_back(e);
  endtask

  // Issues a one-cycle start; returns one cycle later with n = start cycle.
  task automatic run_cmd(input logic f, input logic [8:0] s, input logic [8:0] d,
                         input logic [9:0] l, input logic [31:0] fv, input int lat,
                         output int n);
    @(posedge clk); #1;
    start = 1'b1; fill = f; src = s; dst = d; len = l; fill_val = fv;
    n = cyc;
    if (lat >= 0) exp_done.push_back(n + lat);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    bit seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      n_total++;
      n_bad++;
      $display("FAIL done_timeout: got no done within %0d cycles want done", limit);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1);
  end

  initial begin
    int  n;
    bit  seen;
    for (int i = 0; i < 512; i++) ram[i] <= 32'hA500_0000 + i;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_req", {63'd0, u_bus.mem_req}, 64'd0);
    chk("rst_sel", {63'd0, u_bus.mem_sel}, 64'd0);
    chk("rst_we", {60'd0, u_bus.mem_we}, 64'd0);
    chk("rst_addr", {53'd0, u_bus.mem_addr}, 64'd0);
    chk("rst_wdat", {32'd0, u_bus.mem_wdat}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Copy 0..3 -> 100..103, full grant: done 9 clocks after start
    exp_copy(9'd0, 9'd100, 4);
    run_cmd(1'b0, 9'd0, 9'd100, 10'd4, 32'h0, 9, n);
    @(negedge clk);
    chk("copy_first_sel", {63'd0, u_bus.mem_sel}, 64'd1);
    chk("copy_first_req", {63'd0, u_bus.mem_req}, 64'd1);
    chk("copy_first_busy", {63'd0, busy}, 64'd1);
    wait_done(30);

    // Grant pattern 1,0,0 from the first RD: 4 granted cycles -> done at +11
    exp_copy(9'd20, 9'd40, 2);
    run_cmd(1'b0, 9'd20, 9'd40, 10'd2, 32'h0, 11, n);
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      gnt = ((k % 3) == 0);
      @(negedge clk);
      if (done) seen = 1'b1;
      if (!seen) begin
        @(posedge clk); #1;
      end
    end
    gnt = 1'b1;
    if (!seen) begin
      n_total++;
      n_bad++;
      $display("FAIL stall_timeout: got no done want done");
    end
    chk("stall_ram40", {32'd0, ram[40]}, 64'hA500_0014);
    chk("stall_ram41", {32'd0, ram[41]}, 64'hA500_0015);

    // len=0: done at +2 with no bus activity
    sel_seen = 1'b0;
    run_cmd(1'b0, 9'd5, 9'd6, 10'd0, 32'h0, 2, n);
    wait_done(10);
    chk("len0_no_sel", {63'd0, sel_seen}, 64'd0);

    // Second start while busy is ignored
    exp_copy(9'd200, 9'd300, 8);
    run_cmd(1'b0, 9'd200, 9'd300, 10'd8, 32'h0, 17, n);
    @(negedge clk);
    chk("busy_first_addr", {53'd0, u_bus.mem_addr}, 64'h320);
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b1; src = 9'd50; dst = 9'd400; len = 10'd3;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(60);
    chk("busy_ram400", {32'd0, ram[400]}, 64'hA500_0190);

    // Reset in the third WR cycle of a len=8 copy
    exp_copy(9'd60, 9'd150, 3);
    run_cmd(1'b0, 9'd60, 9'd150, 10'd8, 32'h0, -1, n);
    while (cyc < n + 6) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_sel", {63'd0, u_bus.mem_sel}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("abort_ram152", {32'd0, ram[152]}, 64'hA500_003E);
    chk("abort_ram153", {32'd0, ram[153]}, 64'hA500_0099);

`ifdef BRAM_DMA_FILL_EN
    // Fill 510,511,0,1 with wrap: done at +5
    exp_word(9'd510, 32'hDEAD_BEEF);
    exp_word(9'd511, 32'hDEAD_BEEF);
    exp_word(9'd0, 32'hDEAD_BEEF);
    exp_word(9'd1, 32'hDEAD_BEEF);
    run_cmd(1'b1, 9'd0, 9'd510, 10'd4, 32'hDEAD_BEEF, 5, n);
    @(negedge clk);
    chk("fill_first_addr", {53'd0, u_bus.mem_addr}, 64'h7F8);
    wait_done(20);
`else
    // Fill request without the fill build option performs a copy
    exp_copy(9'd0, 9'd8, 2);
    run_cmd(1'b1, 9'd0, 9'd8, 10'd2, 32'hDEAD_BEEF, 5, n);
    wait_done(20);
    chk("nofill_ram8", {32'd0, ram[8]}, 64'hA500_0000);
    chk("nofill_ram9", {32'd0, ram[9]}, 64'hA500_0001);
`endif

    repeat (5) @(negedge clk);
    chk("wr_queue_drained", 64'(exp_wr.size()), 64'd0);
    chk("done_queue_drained", 64'(exp_done.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
